// File: rtl/data_memory_unit.sv
// data_memory_unit: multi-cycle RV32IM data memory with BUSYWAIT stall and sign/zero-extended sub-word access
module data_memory_unit #(
    parameter int ADDR_WIDTH     = 8,
    parameter int ACCESS_LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ_EN,
    input  logic        WRITE_EN,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [3:0] CNT_INIT = 4'(ACCESS_LATENCY > 1 ? ACCESS_LATENCY - 2 : 0);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [ADDR_WIDTH+1:0] addr_q, op_addr;
    logic [31:0] wdata_q, op_wdata, word, lane_data, load_val;
    logic [2:0] func3_q, op_func3;
    logic store_q, op_store;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic req, accept, commit;
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0] be;
    logic [7:0] rbyte;
    logic [15:0] rhalf;
    logic unused_addr;
    assign unused_addr = ^ADDRESS[31:ADDR_WIDTH+2];
    assign req = READ_EN | WRITE_EN;
    assign accept = state == IDLE && req;
    assign BUSYWAIT = !RESET && (state == ACCESS || accept);
    assign commit = !RESET && ((accept && ACCESS_LATENCY == 1) || (state == ACCESS && cnt == 4'd0));
    // In IDLE the live inputs drive the datapath so a single-cycle access commits on its acceptance edge
    assign op_addr = state == IDLE ? ADDRESS[ADDR_WIDTH+1:0] : addr_q;
    assign op_wdata = state == IDLE ? WRITE_DATA : wdata_q;
    assign op_func3 = state == IDLE ? FUNC3 : func3_q;
    assign op_store = state == IDLE ? WRITE_EN : store_q;
    assign idx = op_addr[ADDR_WIDTH+1:2];
    assign word = mem[idx];
    assign be = op_func3[1:0] == 2'b00 ? 4'b0001 << op_addr[1:0] :
                op_func3[1:0] == 2'b01 ? (op_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign lane_data = op_func3[1:0] == 2'b00 ? {4{op_wdata[7:0]}} :
                       op_func3[1:0] == 2'b01 ? {2{op_wdata[15:0]}} : op_wdata;
    assign rbyte = word[{op_addr[1:0], 3'b000} +: 8];
    assign rhalf = op_addr[1] ? word[31:16] : word[15:0];
    assign load_val = op_func3 == 3'b000 ? {{24{rbyte[7]}}, rbyte} :
                      op_func3 == 3'b001 ? {{16{rhalf[15]}}, rhalf} :
                      op_func3 == 3'b100 ? {24'b0, rbyte} :
                      op_func3 == 3'b101 ? {16'b0, rhalf} : word;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE: if (req) begin
                state_n = ACCESS_LATENCY == 1 ? DONE : ACCESS;
                cnt_n = CNT_INIT;
            end
            ACCESS: begin
                state_n = cnt == 4'd0 ? DONE : ACCESS;
                cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt <= 4'd0;
            READ_DATA <= 32'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (commit && !op_store) READ_DATA <= load_val;
        end
        if (accept) begin
            addr_q <= ADDRESS[ADDR_WIDTH+1:0];
            wdata_q <= WRITE_DATA;
            func3_q <= FUNC3;
            store_q <= WRITE_EN;
        end
    end
    always_ff @(posedge CLK) begin
        if (commit && op_store)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed checks of latency, sub-word access, wrap and reset abort on two latency configs
module tb_data_memory_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic re0 = 0, we0 = 0, re1 = 0, we1 = 0;
    logic [2:0] f30 = 0, f31 = 0;
    logic [31:0] a0 = 0, wd0 = 0, a1 = 0, wd1 = 0;
    logic [31:0] rd0, rd1;
    logic bw0, bw1;
    int checks = 0;
    int failures = 0;
    int nb;
    logic [31:0] rd;

    always #5 clk = ~clk;

    data_memory_unit #(.ADDR_WIDTH(8), .ACCESS_LATENCY(4)) dut (
        .CLK(clk), .RESET(rst), .READ_EN(re0), .WRITE_EN(we0), .FUNC3(f30),
        .ADDRESS(a0), .WRITE_DATA(wd0), .READ_DATA(rd0), .BUSYWAIT(bw0));
    data_memory_unit #(.ADDR_WIDTH(8), .ACCESS_LATENCY(1)) dut1 (
        .CLK(clk), .RESET(rst), .READ_EN(re1), .WRITE_EN(we1), .FUNC3(f31),
        .ADDRESS(a1), .WRITE_DATA(wd1), .READ_DATA(rd1), .BUSYWAIT(bw1));

    // Presents a request in the next cycle and holds it through DONE; returns busy cycles and DONE-cycle READ_DATA
    task automatic op(input bit s, input logic w, input logic r, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d, output int n, output logic [31:0] q);
        @(posedge clk); #1;
        if (s) begin we1 = w; re1 = r; f31 = f; a1 = a; wd1 = d; end
        else begin we0 = w; re0 = r; f30 = f; a0 = a; wd0 = d; end
        n = 0;
        q = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((s ? bw1 : bw0) === 1'b1) n++;
            else begin q = s ? rd1 : rd0; break; end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        re0 = 0; we0 = 0; re1 = 0; we1 = 0;
        @(negedge clk);
        checks++; if (bw0 !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bw0); end
    endtask

    task automatic test_reset();
        re0 = 1;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            checks++; if (rd0 !== 32'd0 || bw0 !== 1'b0) begin failures++; $display("FAIL reset_hold rd=%h bw=%b exp rd=0 bw=0", rd0, bw0); end
        end
        #1 re0 = 0;
        @(posedge clk); #1 rst = 0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (rd0 !== 32'd0 || bw0 !== 1'b0 || rd1 !== 32'd0) begin failures++; $display("FAIL reset_idle rd=%h bw=%b rd1=%h exp 0/0/0", rd0, bw0, rd1); end
        end
    endtask

    task automatic test_word();
        op(0, 1, 0, 3'b010, 32'h20, 32'hDEADBEEF, nb, rd);
        checks++; if (nb !== 4) begin failures++; $display("FAIL sw_busy got=%0d exp=4", nb); end
        op(0, 0, 1, 3'b010, 32'h20, 32'h0, nb, rd);
        checks++; if (nb !== 4) begin failures++; $display("FAIL lw_busy got=%0d exp=4", nb); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_subword();
        op(0, 1, 0, 3'b000, 32'h21, 32'hFFFFFF80, nb, rd);
        op(0, 1, 0, 3'b001, 32'h22, 32'hABCD1234, nb, rd);
        checks++; if (nb !== 4) begin failures++; $display("FAIL sh_busy got=%0d exp=4", nb); end
        op(0, 0, 1, 3'b010, 32'h20, 0, nb, rd);
        checks++; if (rd !== 32'h123480EF) begin failures++; $display("FAIL lw_merged got=%h exp=123480ef", rd); end
        op(0, 0, 1, 3'b000, 32'h21, 0, nb, rd);
        checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb got=%h exp=ffffff80", rd); end
        op(0, 0, 1, 3'b100, 32'h21, 0, nb, rd);
        checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h exp=00000080", rd); end
        op(0, 0, 1, 3'b001, 32'h22, 0, nb, rd);
        checks++; if (rd !== 32'h00001234) begin failures++; $display("FAIL lh_hi got=%h exp=00001234", rd); end
        op(0, 0, 1, 3'b101, 32'h20, 0, nb, rd);
        checks++; if (rd !== 32'h000080EF) begin failures++; $display("FAIL lhu got=%h exp=000080ef", rd); end
        op(0, 0, 1, 3'b001, 32'h20, 0, nb, rd);
        checks++; if (rd !== 32'hFFFF80EF) begin failures++; $display("FAIL lh_lo got=%h exp=ffff80ef", rd); end
        op(0, 0, 1, 3'b000, 32'h23, 0, nb, rd);
        checks++; if (rd !== 32'h00000012) begin failures++; $display("FAIL lb_b3 got=%h exp=00000012", rd); end
        op(0, 0, 1, 3'b011, 32'h22, 0, nb, rd);
        checks++; if (rd !== 32'h123480EF) begin failures++; $display("FAIL f3_011_as_w got=%h exp=123480ef", rd); end
        idle();
    endtask

    task automatic test_wrap();
        op(0, 1, 0, 3'b010, 32'h403, 32'hA5A5A5A5, nb, rd);
        op(0, 0, 1, 3'b010, 32'h000, 0, nb, rd);
        checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL wrap_lw got=%h exp=a5a5a5a5", rd); end
        op(0, 0, 1, 3'b001, 32'h001, 0, nb, rd);
        checks++; if (rd !== 32'hFFFFA5A5) begin failures++; $display("FAIL lh_odd got=%h exp=ffffa5a5", rd); end
        op(0, 0, 1, 3'b010, 32'hFFFFFC00, 0, nb, rd);
        checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL wrap_high got=%h exp=a5a5a5a5", rd); end
        idle();
    endtask

    task automatic test_reset_abort();
        op(0, 1, 0, 3'b010, 32'h10, 32'h11111111, nb, rd);
        idle();
        @(posedge clk); #1;
        we0 = 1; f30 = 3'b010; a0 = 32'h10; wd0 = 32'hBAD0BAD0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bw0 !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", bw0); end
        rst = 1;
        @(negedge clk);
        checks++; if (bw0 !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bw0); end
        @(posedge clk); #1;
        rst = 0; we0 = 0;
        @(negedge clk);
        checks++; if (bw0 !== 1'b0 || rd0 !== 32'd0) begin failures++; $display("FAIL abort_after bw=%b rd=%h exp 0/0", bw0, rd0); end
        op(0, 0, 1, 3'b010, 32'h10, 0, nb, rd);
        checks++; if (nb !== 4) begin failures++; $display("FAIL abort_lw_busy got=%0d exp=4", nb); end
        checks++; if (rd !== 32'h11111111) begin failures++; $display("FAIL abort_lw got=%h exp=11111111", rd); end
        idle();
    endtask

    task automatic test_latency1();
        op(1, 1, 0, 3'b010, 32'h8, 32'h0CAFEF00, nb, rd);
        checks++; if (nb !== 1) begin failures++; $display("FAIL l1_sw_busy got=%0d exp=1", nb); end
        op(1, 0, 1, 3'b010, 32'h8, 0, nb, rd);
        checks++; if (nb !== 1) begin failures++; $display("FAIL l1_lw_busy got=%0d exp=1", nb); end
        checks++; if (rd !== 32'h0CAFEF00) begin failures++; $display("FAIL l1_lw got=%h exp=0cafef00", rd); end
        op(1, 1, 1, 3'b010, 32'hC, 32'h13572468, nb, rd);
        checks++; if (rd !== 32'h0CAFEF00) begin failures++; $display("FAIL both_rd_hold got=%h exp=0cafef00", rd); end
        op(1, 0, 1, 3'b010, 32'hC, 0, nb, rd);
        checks++; if (rd !== 32'h13572468) begin failures++; $display("FAIL both_wrote got=%h exp=13572468", rd); end
        idle();
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_wrap();
        test_reset_abort();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Multi-cycle RV32IM data memory serving the MEM stage. It accepts load/store requests, holds the pipeline with BUSYWAIT for a fixed access latency, and performs byte/halfword/word accesses with RISC-V sign/zero extension. It returns load data on READ_DATA, which is the DMEM_OUT input of the MEM/WB pipeline register. Its BUSYWAIT output is the stall input of every pipeline register.

## Interface
- ADDR_WIDTH, 8: word-address bits; capacity 2^ADDR_WIDTH 32-bit words.
- ACCESS_LATENCY, 4: BUSYWAIT-high cycles per access; legal range 1..15.

- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- READ_EN  in  1  load request; held stable by the stalled pipeline until the access completes.
- WRITE_EN  in  1  store request; same hold rule as READ_EN.
- FUNC3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ADDRESS  in  32  byte address (ALU result).
- WRITE_DATA  in  32  store data in bits [31:0]; the low byte or halfword is used for SB/SH.
- READ_DATA  out  32  registered, extended load result.
- BUSYWAIT  out  1  stall; combinational from state and request.

## Operation
- States: IDLE, ACCESS, DONE; 4-bit down-counter CNT.
- IDLE, no request: BUSYWAIT=0.
- IDLE, READ_EN or WRITE_EN high: BUSYWAIT=1 in the same cycle. Latch ADDRESS, FUNC3, WRITE_DATA and the op type.
  - ACCESS_LATENCY=1: commit at this edge and go to DONE.
  - Otherwise: go to ACCESS with CNT=ACCESS_LATENCY-2.
- ACCESS: BUSYWAIT=1.
  - CNT=0: commit and go to DONE.
  - Otherwise: decrement CNT.
- DONE: BUSYWAIT=0 for exactly one cycle, even though the old request is still asserted. The pipeline advances at this edge. Next state is IDLE unconditionally.
- Commit behaviour:
  - Store: write the selected byte lanes of word ADDRESS[ADDR_WIDTH+1:2].
  - Load: update READ_DATA; it then holds until the next load commit.
- Lane selection:
  - Byte: ADDRESS[1:0].
  - Halfword: ADDRESS[1]; ADDRESS[0] is ignored.
  - Word: ADDRESS[1:0] are ignored. There is no misalignment trap.
- Extension: B/H sign-extend; BU/HU zero-extend.
- Unlisted FUNC3 values (011, 110, 111) are treated as W. Stores with FUNC3 1xx use the low two bits (100=SB, 101=SH).
- ADDRESS bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo capacity.
- READ_EN and WRITE_EN both high: treated as a store; READ_DATA is unchanged.
- Memory contents are not initialised or cleared by RESET.

## Timing
- RESET high at a posedge:
  - state=IDLE, CNT=0, READ_DATA=0.
  - The pending access is aborted with no write commit, even on the commit edge.
  - BUSYWAIT is forced 0 while RESET is high.
- Stall length is exactly ACCESS_LATENCY cycles, starting in the cycle the request first appears.
- Cycle ACCESS_LATENCY (counting the first request cycle as 0) is DONE.
- READ_DATA is valid from the start of DONE.
- Back-to-back memory ops: after DONE there is one IDLE cycle, which is also the first BUSYWAIT cycle of the next request. So the per-access period is ACCESS_LATENCY+1.
- Inputs are sampled only at acceptance. Changes during ACCESS or DONE are ignored.

## Test plan
- Reset and idle:
  - Stimulus: RESET for 2 cycles, then no request.
  - Required: READ_DATA=0 and BUSYWAIT=0 throughout.
  - Assert RESET during ACCESS of an SW to 0x10: BUSYWAIT drops and a later LW 0x10 does not return the aborted data.
- Word round-trip with ACCESS_LATENCY=4:
  - Stimulus: SW 0xDEADBEEF to 0x20, then LW 0x20.
  - Required: BUSYWAIT is high exactly 4 cycles per access with one low DONE cycle between. READ_DATA=0xDEADBEEF in the LW DONE cycle.
- Byte and halfword stores/loads, starting from word 0x20=0xDEADBEEF:
  - Stores: SB 0x80 to 0x21, then SH 0x1234 to 0x22.
  - Required: LW 0x20=0x123480EF.
  - Loads: LB 0x21=0xFFFFFF80; LBU 0x21=0x00000080; LH 0x22=0x00001234; LHU 0x20=0x000080EF; LH 0x20=0xFFFF80EF.
- Alignment and wrap with ADDR_WIDTH=8:
  - Stimulus: SW 0xA5A5A5A5 to 0x403.
  - Required: LW 0x000 returns 0xA5A5A5A5.
  - LH 0x001 returns the halfword at 0x000.
- Latency corner with ACCESS_LATENCY=1:
  - Stimulus: LW with the request held.
  - Required: BUSYWAIT high 1 cycle, low in DONE; READ_DATA valid in DONE.
  - Also: READ_EN and WRITE_EN both high writes memory and leaves READ_DATA unchanged.
